test_unit_scheduler: RTL
========================

Name: test_unit_scheduler

Overview:
- Synthesizable sequencer that runs NUM test units one after another.
- Per unit: issues a one-cycle start pulse, waits for done or timeout, and records pass, fail or timeout into per-unit bitmaps. Raises a summary verdict when the sequence ends.
- Sits in the simulation top between the bench and the unit instances. It generalises the bench's fixed pass-flag arrays into a parametrised, self-timed harness.

Parameters:
- NUM, 4, number of test units (>=1).
- TIMEOUT, 1024, max cycles in WAIT before a unit is declared timed out (>=2).
- GAP, 2, idle cycles inserted after each unit completes (>=0).
- IW, $clog2(NUM) (min 1), width of cur_unit.

Ports:
- clock  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a run; sampled only in IDLE.
- unit_en  input  NUM  enable mask; bit i=0 skips unit i.
- unit_start  output  NUM  one-hot, one-cycle start pulse to unit i.
- unit_done  input  NUM  unit i finished; only bit cur_unit is honoured.
- unit_pass  input  NUM  verdict of unit i, sampled together with unit_done[i].
- busy  output  1  high from the cycle after start acceptance until FINISH is left.
- cur_unit  output  IW  index of the unit being launched or awaited.
- pass_map  output  NUM  bit i set when unit i reported done with pass=1.
- fail_map  output  NUM  bit i set on done with pass=0, or on timeout.
- timeout_map  output  NUM  bit i set on timeout of unit i.
- all_done  output  1  one-cycle pulse when the run completes.
- all_pass  output  1  registered verdict: fail_map==0 at completion.

Behaviour:
- Reset (async, rst_n=0): state IDLE, idx=0, timer=0, gap counter=0, all outputs 0. Reset mid-run aborts immediately; no all_done is issued.
- State IDLE:
  - start=1 -> clear pass/fail/timeout maps and all_pass, idx=0, go to SEEK.
  - start is ignored in every other state.
- State SEEK:
  - idx==NUM -> FINISH.
  - unit_en[idx]=0 -> idx+1, stay in SEEK (one cycle per skipped unit).
  - Otherwise -> LAUNCH.
  - unit_en is sampled live, so changing it during a run affects only units not yet reached.
- State LAUNCH: unit_start[idx]=1 for exactly this cycle, timer=0, -> WAIT.
- State WAIT: timer increments each cycle.
  - unit_done[idx]=1 -> set pass_map[idx] or fail_map[idx] per unit_pass[idx], -> GAP.
  - Else if timer==TIMEOUT-1 -> set timeout_map[idx] and fail_map[idx], -> GAP.
  - Done on the same cycle as the timeout: done wins and timeout_map stays 0.
  - Done bits of other units are ignored in all states.
  - Done during LAUNCH is ignored (the unit must answer no earlier than the cycle after unit_start).
- State GAP: hold for GAP cycles, then idx+1 -> SEEK. GAP=0 goes to SEEK on the next cycle.
- State FINISH: all_done=1 for one cycle, all_pass <= (fail_map==0), -> IDLE.
  - all_pass and the maps hold their values until the next accepted start.
  - All units disabled -> all_pass=1.
- cur_unit = idx[IW-1:0] in every state; idx is internally $clog2(NUM+1) bits wide.
- Latency (unit 0 enabled): start high at edge k -> unit_start[0] high in the cycle after edge k+1. Done high at edge t -> map bit visible after edge t.
- Per enabled unit the cost is 1 (SEEK) + 1 (LAUNCH) + wait + GAP cycles. A skipped unit costs 1 cycle.

Test Plan:
- NUM=4, TIMEOUT=16, GAP=2, unit_en=4'b1111, every unit asserts done with pass=1 three cycles after its start pulse -> four start pulses, each 7 cycles apart; pass_map=4'b1111, fail_map=0, all_done single pulse, all_pass=1.
- unit_en=4'b1010 -> start pulses only on bits 1 and 3; pass_map=4'b1010; bits 0 and 2 stay 0 in all maps.
- Unit 2 never responds -> exactly 16 WAIT cycles, then timeout_map=4'b0100, fail_map=4'b0100, unit 3 still runs, all_pass=0.
- Unit 1 asserts done on the 16th WAIT cycle (timer==15) with pass=1 -> pass_map[1]=1, timeout_map[1]=0. Unit 0 asserts done with pass=0 -> fail_map[0]=1. Stray unit_done[3] pulses while unit 1 is active are ignored.
- rst_n pulled low while waiting on unit 2 -> all outputs 0 asynchronously. A following start runs cleanly from unit 0 with the maps cleared.
- start re-pulsed while busy=1 -> no effect. A start pulse in IDLE after completion clears the maps and all_pass on acceptance.

Source files
------------

// File: rtl/test_unit_scheduler.sv
// test_unit_scheduler
// Runs NUM test units one after another: pulses each enabled unit's start,
// waits for its done (or a timeout), records the outcome in per-unit
// bitmaps and raises a one-cycle completion pulse with an overall verdict.

module test_unit_scheduler #(
    parameter int NUM     = 4,
    parameter int TIMEOUT = 1024,
    parameter int GAP     = 2,
    parameter int IW      = (NUM > 1) ? $clog2(NUM) : 1
) (
    input  logic           clock,
    input  logic           rst_n,
    input  logic           start,
    input  logic [NUM-1:0] unit_en,
    output logic [NUM-1:0] unit_start,
    input  logic [NUM-1:0] unit_done,
    input  logic [NUM-1:0] unit_pass,
    output logic           busy,
    output logic [IW-1:0]  cur_unit,
    output logic [NUM-1:0] pass_map,
    output logic [NUM-1:0] fail_map,
    output logic [NUM-1:0] timeout_map,
    output logic           all_done,
    output logic           all_pass
);

    // idx must be able to hold NUM itself, which marks the end of the run
    localparam int XW = $clog2(NUM + 1);
    localparam int TW = $clog2(TIMEOUT);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [XW-1:0]  IDX_END    = XW'(NUM);
    localparam logic [XW-1:0]  IDX_ONE    = XW'(1);
    localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0]  GAP_LAST   = (GAP > 0) ? GW'(GAP - 1) : '0;
    localparam logic [NUM-1:0] ONE_HOT0   = NUM'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEEK,
        S_LAUNCH,
        S_WAIT,
        S_GAP,
        S_FINISH
    } state_t;

    state_t         state;
    logic [XW-1:0]  idx;
    logic [TW-1:0]  timer;
    logic [GW-1:0]  gap_cnt;

    logic [NUM-1:0] unit_sel;
    logic           en_cur;
    logic           done_cur;
    logic           pass_cur;
    logic           timed_out;
    logic           unit_over;

    // One-hot select of the current unit; all zero once idx reaches NUM,
    // so the per-unit lookups below never index out of range.
    assign unit_sel  = ONE_HOT0 << idx;
    assign en_cur    = |(unit_en & unit_sel);
    assign done_cur  = |(unit_done & unit_sel);
    assign pass_cur  = |(unit_pass & unit_sel);
    assign timed_out = (timer == TIMER_LAST);
    assign unit_over = done_cur || timed_out;

    assign cur_unit  = idx[IW-1:0];

    // Sequencer: walks the units, times each wait and accumulates the maps
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            idx         <= '0;
            timer       <= '0;
            gap_cnt     <= '0;
            unit_start  <= '0;
            busy        <= 1'b0;
            pass_map    <= '0;
            fail_map    <= '0;
            timeout_map <= '0;
            all_done    <= 1'b0;
            all_pass    <= 1'b0;
        end else begin
            unit_start <= '0;
            all_done   <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        pass_map    <= '0;
                        fail_map    <= '0;
                        timeout_map <= '0;
                        all_pass    <= 1'b0;
                        idx         <= '0;
                        busy        <= 1'b1;
                        state       <= S_SEEK;
                    end
                end

                S_SEEK: begin
                    if (idx == IDX_END) begin
                        all_done <= 1'b1;
                        state    <= S_FINISH;
                    end else if (!en_cur) begin
                        idx <= idx + IDX_ONE;
                    end else begin
                        unit_start <= unit_sel;
                        state      <= S_LAUNCH;
                    end
                end

                S_LAUNCH: begin
                    timer <= '0;
                    state <= S_WAIT;
                end

                S_WAIT: begin
                    timer <= timer + 1'b1;
                    if (done_cur) begin
                        if (pass_cur) begin
                            pass_map <= pass_map | unit_sel;
                        end else begin
                            fail_map <= fail_map | unit_sel;
                        end
                    end else if (timed_out) begin
                        timeout_map <= timeout_map | unit_sel;
                        fail_map    <= fail_map | unit_sel;
                    end
                    if (unit_over) begin
                        if (GAP == 0) begin
                            idx   <= idx + IDX_ONE;
                            state <= S_SEEK;
                        end else begin
                            gap_cnt <= '0;
                            state   <= S_GAP;
                        end
                    end
                end

                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        idx   <= idx + IDX_ONE;
                        state <= S_SEEK;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end

                S_FINISH: begin
                    all_pass <= (fail_map == '0);
                    busy     <= 1'b0;
                    state    <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
